// File: rtl/dm_access_unit.sv
// Data-memory stage access unit: turns load/store control into a valid/ready bus request,
// aligns/extends load data and stalls the pipeline while an access is outstanding.
// Optional `DM_MISALIGN_TRAP_EN adds a misalign output and suppresses misaligned requests.
module dm_access_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_mem_read,
  input  logic              m_mem_write,
  input  logic [2:0]        m_funct3,
  input  logic [XLEN-1:0]   m_addr,
  input  logic [XLEN-1:0]   m_wdata,
  input  logic [XLEN-1:0]   m_alu_result,
  output logic [XLEN-1:0]   m_dataout,
  output logic              stall,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN/8-1:0] dbus_be,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic              dbus_rsp_valid,
  input  logic [XLEN-1:0]   dbus_rdata
`ifdef DM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] load_value;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic            mem_op;
  logic            is_byte;
  logic            is_half;
  logic            trap;

  assign mem_op    = m_valid & (m_mem_read | m_mem_write);
  assign dbus_we   = m_mem_write;
  assign dbus_addr = {m_addr[XLEN-1:2], 2'b00};

  // Stores size on the exact funct3 code; loads ignore the unsigned bit.
  assign is_byte = m_mem_write ? (m_funct3 == 3'b000) : (m_funct3[1:0] == 2'b00);
  assign is_half = m_mem_write ? (m_funct3 == 3'b001) : (m_funct3[1:0] == 2'b01);

`ifdef DM_MISALIGN_TRAP_EN
  logic is_word;
  logic misalign_q;

  assign is_word = !is_byte && !is_half;
  assign trap    = (is_half & m_addr[0]) | (is_word & (m_addr[1:0] != 2'b00));

  // High only for the DONE cycle entered straight from IDLE on a trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= (state == IDLE) && mem_op && trap;
  end

  assign misalign = misalign_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = m_wdata;
    if (m_mem_write) begin
      if (is_byte) begin
        dbus_be    = 4'b0001 << m_addr[1:0];
        dbus_wdata = {4{m_wdata[7:0]}};
      end else if (is_half) begin
        dbus_be    = 4'b0011 << {m_addr[1], 1'b0};
        dbus_wdata = {2{m_wdata[15:0]}};
      end
    end
  end

  always_comb begin
    load_byte = dbus_rdata[7:0];
    case (m_addr[1:0])
      2'b00:   load_byte = dbus_rdata[7:0];
      2'b01:   load_byte = dbus_rdata[15:8];
      2'b10:   load_byte = dbus_rdata[23:16];
      default: load_byte = dbus_rdata[31:24];
    endcase
    load_half = m_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (m_funct3)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'b0, load_byte};
      3'b101:  load_value = {16'b0, load_half};
      default: load_value = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mem_op) state_next = trap ? DONE : REQ;
      REQ:      if (dbus_req_ready) state_next = WAIT_RSP;
      WAIT_RSP: if (dbus_rsp_valid) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    stall          = 1'b0;
    dbus_req_valid = 1'b0;
    m_dataout      = m_alu_result;
    case (state)
      IDLE:     stall = mem_op;
      REQ: begin
        stall          = 1'b1;
        dbus_req_valid = 1'b1;
      end
      WAIT_RSP: stall = 1'b1;
      DONE:     m_dataout = result_q;
      default:  stall = 1'b0;
    endcase
  end

  // Stores and trapped accesses hand a zero to the DM/WB register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      result_q <= '0;
    else if (state == WAIT_RSP && dbus_rsp_valid)
      result_q <= m_mem_write ? '0 : load_value;
    else if (state == IDLE && mem_op && trap)
      result_q <= '0;
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed self-checking bench for dm_access_unit; honours `DM_MISALIGN_TRAP_EN if defined.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_mem_read = 1'b0;
  logic        m_mem_write = 1'b0;
  logic [2:0]  m_funct3 = 3'b000;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_alu_result = '0;
  logic [31:0] m_dataout;
  logic        stall;
  logic        dbus_req_valid;
  logic        dbus_req_ready = 1'b0;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_rsp_valid = 1'b0;
  logic [31:0] dbus_rdata = '0;
`ifdef DM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int          checks = 0;
  int          errors = 0;

  int          stall_cycles;
  int          req_cycles;
  int          req_unstable;
  int          timed_out;
  logic [31:0] result;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        done_misalign;

  dm_access_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .m_valid        (m_valid),
    .m_mem_read     (m_mem_read),
    .m_mem_write    (m_mem_write),
    .m_funct3       (m_funct3),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_alu_result   (m_alu_result),
    .m_dataout      (m_dataout),
    .stall          (stall),
    .dbus_req_valid (dbus_req_valid),
    .dbus_req_ready (dbus_req_ready),
    .dbus_we        (dbus_we),
    .dbus_addr      (dbus_addr),
    .dbus_be        (dbus_be),
    .dbus_wdata     (dbus_wdata),
    .dbus_rsp_valid (dbus_rsp_valid),
    .dbus_rdata     (dbus_rdata)
`ifdef DM_MISALIGN_TRAP_EN
    ,
    .misalign       (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives the DM-stage operands just after a falling edge.
  task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu);
    @(negedge clk);
    m_valid      = valid;
    m_mem_read   = rd;
    m_mem_write  = wr;
    m_funct3     = f3;
    m_addr       = addr;
    m_wdata      = wdata;
    m_alu_result = alu;
    #1;
  endtask

  // Bus responder: holds ready low for ready_low request cycles, answers rsp_delay cycles
  // after acceptance, and stops in the first non-stalled cycle (the DONE cycle).
  task automatic runBus(input int ready_low, input int rsp_delay, input logic [31:0] rdata);
    int  low_cnt  = 0;
    int  wait_cnt = 0;
    bit  accepted = 0;
    bit  done     = 0;
    stall_cycles  = 0;
    req_cycles    = 0;
    req_unstable  = 0;
    timed_out     = 1;
    result        = '0;
    done_misalign = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      dbus_req_ready = 1'b0;
      dbus_rsp_valid = 1'b0;
      if (stall) begin
        stall_cycles++;
        if (dbus_req_valid) begin
          if (req_cycles == 0) begin
            req_addr  = dbus_addr;
            req_be    = dbus_be;
            req_wdata = dbus_wdata;
            req_we    = dbus_we;
          end else if (dbus_addr !== req_addr || dbus_be !== req_be ||
                       dbus_wdata !== req_wdata || dbus_we !== req_we) begin
            req_unstable++;
          end
          req_cycles++;
          if (low_cnt < ready_low) low_cnt++;
          else dbus_req_ready = 1'b1;
        end else if (accepted) begin
          if (wait_cnt == rsp_delay) begin
            dbus_rsp_valid = 1'b1;
            dbus_rdata     = rdata;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        done      = 1;
        timed_out = 0;
        result    = m_dataout;
`ifdef DM_MISALIGN_TRAP_EN
        done_misalign = misalign;
`endif
      end
      if (dbus_req_valid && dbus_req_ready) accepted = 1;
      if (!done) begin
        @(negedge clk);
        #1;
      end
    end
    dbus_req_ready = 1'b0;
    dbus_rsp_valid = 1'b0;
    checkOutput("bus_timeout", timed_out, 0);
  endtask

  initial begin
    $display("[TB] starting dm_access_unit bench");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_req_valid", dbus_req_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // Non-memory instruction passes the ALU result straight through.
    applyStimulus(1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h1234_5678);
    checkOutput("alu_stall", stall, 0);
    checkOutput("alu_dataout", m_dataout, 32'h1234_5678);
    checkOutput("alu_req_valid", dbus_req_valid, 0);

    // Load control without m_valid is not a memory op.
    applyStimulus(0, 1, 0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D);
    checkOutput("novalid_stall", stall, 0);
    checkOutput("novalid_dataout", m_dataout, 32'h0BAD_F00D);

    // LB at 0x103, zero-wait bus.
    applyStimulus(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h0);
    runBus(0, 0, 32'h80FF_0000);
    checkOutput("lb_addr", req_addr, 32'h100);
    checkOutput("lb_be", {28'b0, req_be}, 32'hF);
    checkOutput("lb_we", {31'b0, req_we}, 0);
    checkOutput("lb_stalls", stall_cycles, 3);
    checkOutput("lb_data", result, 32'hFFFF_FF80);

    applyStimulus(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h0);
    runBus(0, 0, 32'h80FF_0000);
    checkOutput("lbu_stalls", stall_cycles, 3);
    checkOutput("lbu_data", result, 32'h0000_0080);

    // Halfword loads from the upper half.
    applyStimulus(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h0);
    runBus(0, 0, 32'h8001_1234);
    checkOutput("lh_data", result, 32'hFFFF_8001);
    applyStimulus(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h0);
    runBus(0, 0, 32'h8001_1234);
    checkOutput("lhu_data", result, 32'h0000_8001);

    // SH at 0x202.
    applyStimulus(1, 0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'h0);
    runBus(0, 0, 32'hFFFF_FFFF);
    checkOutput("sh_addr", req_addr, 32'h200);
    checkOutput("sh_be", {28'b0, req_be}, 32'hC);
    checkOutput("sh_wdata", req_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_we", {31'b0, req_we}, 1);
    checkOutput("sh_result", result, 32'h0);

    // SB at 0x101.
    applyStimulus(1, 0, 1, 3'b000, 32'h101, 32'h1234_565A, 32'h0);
    runBus(0, 0, 32'h0);
    checkOutput("sb_be", {28'b0, req_be}, 32'h2);
    checkOutput("sb_wdata", req_wdata, 32'h5A5A_5A5A);

    // Read and write both set behaves as a store.
    applyStimulus(1, 1, 1, 3'b010, 32'h500, 32'h0102_0304, 32'h0);
    runBus(0, 0, 32'hDEAD_BEEF);
    checkOutput("rw_we", {31'b0, req_we}, 1);
    checkOutput("rw_be", {28'b0, req_be}, 32'hF);
    checkOutput("rw_wdata", req_wdata, 32'h0102_0304);
    checkOutput("rw_result", result, 32'h0);

    // LW with ready low for 4 cycles and response delayed 2 cycles.
    applyStimulus(1, 1, 0, 3'b010, 32'h040, 32'h0, 32'h0);
    runBus(4, 2, 32'h1357_9BDF);
    checkOutput("lw_slow_stalls", stall_cycles, 9);
    checkOutput("lw_slow_req_cycles", req_cycles, 5);
    checkOutput("lw_slow_req_stable", req_unstable, 0);
    checkOutput("lw_slow_data", result, 32'h1357_9BDF);

    // Reset while waiting for the response; the late response must be ignored.
    applyStimulus(1, 1, 0, 3'b010, 32'h400, 32'h0, 32'h1111_1111);
    @(negedge clk);
    dbus_req_ready = 1'b1;
    #1;
    checkOutput("rst_req_valid", dbus_req_valid, 1);
    @(negedge clk);
    dbus_req_ready = 1'b0;
    #1;
    checkOutput("rst_wait_stall", stall, 1);
    reset   = 1'b1;
    m_valid = 1'b0;
    #1;
    checkOutput("rst_mid_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dbus_rsp_valid = 1'b1;
    dbus_rdata     = 32'hDEAD_BEEF;
    m_alu_result   = 32'h2222_2222;
    #1;
    checkOutput("rst_rsp_stall", stall, 0);
    checkOutput("rst_rsp_dataout", m_dataout, 32'h2222_2222);
    @(negedge clk);
    dbus_rsp_valid = 1'b0;
    m_alu_result   = 32'h3333_3333;
    #1;
    checkOutput("rst_after_stall", stall, 0);
    checkOutput("rst_after_req_valid", dbus_req_valid, 0);
    checkOutput("rst_after_dataout", m_dataout, 32'h3333_3333);

    // Misaligned LW at 0x302.
    applyStimulus(1, 1, 0, 3'b010, 32'h302, 32'h0, 32'h0);
    runBus(0, 0, 32'hCAFE_F00D);
`ifdef DM_MISALIGN_TRAP_EN
    checkOutput("mis_req_cycles", req_cycles, 0);
    checkOutput("mis_stalls", stall_cycles, 1);
    checkOutput("mis_result", result, 32'h0);
    checkOutput("mis_flag", {31'b0, done_misalign}, 1);
    applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("mis_flag_clear", {31'b0, misalign}, 0);
`else
    checkOutput("mis_addr", req_addr, 32'h300);
    checkOutput("mis_stalls", stall_cycles, 3);
    checkOutput("mis_result", result, 32'hCAFE_F00D);
    applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
`endif
    checkOutput("final_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
